// File: rtl/div_unit.sv
// 32-bit iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to retire divide-by-zero and signed overflow directly from IDLE.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        ready,
    output logic        busy
);

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST_SPECIAL = 1'b1;
`else
    localparam bit FAST_SPECIAL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs, spec_val;
    logic        is_rem, q_neg, r_neg, special;

    // Request decode; op[0] set means unsigned
    logic        a_neg, b_neg, div_zero, ovf, in_special;
    logic [31:0] a_mag, b_mag, in_spec_val;

    assign a_neg       = ~op[0] & a[31];
    assign b_neg       = ~op[0] & b[31];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;
    assign div_zero    = (b == 32'h0);
    assign ovf         = ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    assign in_special  = div_zero | ovf;
    assign in_spec_val = div_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                                  : (op[1] ? 32'h0 : 32'h8000_0000);

    // One restoring step: the dividend shifts out of quo MSB-first as quotient bits shift in
    logic [32:0] shifted, diff;
    logic        ge;
    logic [31:0] rem_step, quo_step, q_fin, r_fin, calc_res;

    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, dvs};
    assign ge       = ~diff[32];
    assign rem_step = ge ? diff[31:0] : shifted[31:0];
    assign quo_step = {quo[30:0], ge};
    assign q_fin    = q_neg ? -quo_step : quo_step;
    assign r_fin    = r_neg ? -rem_step : rem_step;
    assign calc_res = special ? spec_val : (is_rem ? r_fin : q_fin);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (FAST_SPECIAL && in_special) ? DONE : CALC;
            CALC: if (cnt == 5'd0) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= 5'd0;
            quo      <= 32'h0;
            rem      <= 32'h0;
            dvs      <= 32'h0;
            spec_val <= 32'h0;
            is_rem   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            special  <= 1'b0;
            result   <= 32'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt      <= 5'd31;
                    quo      <= a_mag;
                    rem      <= 32'h0;
                    dvs      <= b_mag;
                    is_rem   <= op[1];
                    q_neg    <= a_neg ^ b_neg;
                    r_neg    <= a_neg;
                    special  <= in_special;
                    spec_val <= in_spec_val;
                    if (FAST_SPECIAL && in_special) result <= in_spec_val;
                end
                CALC: begin
                    quo <= quo_step;
                    rem <= rem_step;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) result <= calc_res;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected result and completion cycle,
// and a negedge monitor checks every ready pulse against the queue head.
module tb_div_unit;
    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int LSP = 1;
`else
    localparam int LSP = 33;
`endif

    logic        clk, resetn, start;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic        ready, busy;

    div_unit dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .result(result), .ready(ready), .busy(busy)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    always @(negedge clk) begin
        if (resetn && ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious_ready: ready=1 with nothing outstanding, result=%h", result);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_res"}, result, e.res);
                chk({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Wait for IDLE, present one request for one edge, then scramble inputs
    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] er, input int lat,
                         input bit track);
        int w = 0;
        @(negedge clk);
        while (busy && w < 200) begin @(negedge clk); w++; end
        if (busy) begin
            total++;
            $display("FAIL %s_idle_wait: busy=%b want 0", nm, busy);
        end
        start = 1'b1; op = o; a = av; b = bv;
        if (track) sb.push_back('{er, cyc + lat, nm});
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    endtask

    initial begin
        int w;
        logic [31:0] av, bv;
        logic [1:0]  o;
        resetn = 1'b0; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        resetn = 1'b1;

        issue("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
        issue("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33, 1);
        repeat (10) @(negedge clk);
        chk("hold_in_calc", result, 32'd14);
        chk("busy_in_calc", {31'h0, busy}, 32'h1);
        issue("div_m100_7",   DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33, 1);
        issue("rem_m100_7",   REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, 1);
        issue("div_100_m7",   DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1);
        issue("rem_100_m7",   REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         33, 1);
        issue("div_m100_m7",  DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        33, 1);
        issue("rem_m100_m7",  REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 1);
        issue("div_ovf",      DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LSP, 1);
        issue("rem_ovf",      REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LSP, 1);
        issue("divu_ovf_ops", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33, 1);
        issue("divu_by0",     DIVU, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, LSP, 1);
        issue("remu_by0",     REMU, 32'h1234_5678, 32'h0,         32'h1234_5678, LSP, 1);
        issue("div_m5_by0",   DIV,  32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFF, LSP, 1);
        issue("rem_m5_by0",   REM,  32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, LSP, 1);
        issue("divu_max_1",   DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1);
        issue("remu_max_msb", REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33, 1);

        // start held high with operands changing every cycle: accepted every 34th edge
        w = 0;
        @(negedge clk);
        while (busy && w < 200) begin @(negedge clk); w++; end
        for (int k = 0; k < 102; k++) begin
            o  = (k % 3 == 1) ? REMU : DIVU;
            av = 32'd5000 + 32'(k) * 32'd131;
            bv = 32'(k) + 32'd2;
            start = 1'b1; op = o; a = av; b = bv;
            if (k % 34 == 0)
                sb.push_back('{(o == REMU) ? av % bv : av / bv, cyc + 33, $sformatf("burst%0d", k)});
            @(negedge clk);
        end
        start = 1'b0;

        // Abort mid-calculation, then a fresh request
        issue("divu_abort", DIVU, 32'd1000, 32'd3, 32'd0, 0, 0);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_ready", {31'h0, ready}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        issue("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 33, 1);

        w = 0;
        while (sb.size() > 0 && w < 300) begin @(negedge clk); w++; end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain_timeout: pending %0d want 0", sb.size());
        end
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
